// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID stage: instruction decode, writeback bypass, load-use stall and ID/EX register
module decode_stage (
  input  logic        cclk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  output logic [4:0]  read_reg_0,
  output logic [4:0]  read_reg_1,
  input  logic [31:0] reg0,
  input  logic [31:0] reg1,
  input  logic        wb_write,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_op_a,
  output logic [31:0] ex_op_b,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_dest,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_alu_src,
  output logic [3:0]  ex_alu_ctrl,
  output logic        ex_illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign opcode   = if_instr[31:26];
  assign rs       = if_instr[25:21];
  assign rt       = if_instr[20:16];
  assign rd       = if_instr[15:11];
  assign imm16    = if_instr[15:0];
  assign funct    = if_instr[5:0];
  assign imm_sext = {{16{imm16[15]}}, imm16};
  assign imm_zext = {16'd0, imm16};

  assign read_reg_0 = rs;
  assign read_reg_1 = rt;

  logic        dec_legal;
  logic        dec_writes;
  logic        dec_reg_write;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_alu_src;
  logic [3:0]  dec_alu_ctrl;
  logic [4:0]  dec_dest;
  logic [31:0] dec_imm;

  always_comb begin
    dec_legal     = 1'b0;
    dec_writes    = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_alu_src   = 1'b0;
    dec_alu_ctrl  = ALU_AND;
    dec_dest      = 5'd0;
    dec_imm       = 32'd0;
    case (opcode)
      OP_RTYPE: begin
        dec_legal  = 1'b1;
        dec_writes = 1'b1;
        dec_dest   = rd;
        case (funct)
          FN_ADD:  dec_alu_ctrl = ALU_ADD;
          FN_SUB:  dec_alu_ctrl = ALU_SUB;
          FN_AND:  dec_alu_ctrl = ALU_AND;
          FN_OR:   dec_alu_ctrl = ALU_OR;
          FN_SLT:  dec_alu_ctrl = ALU_SLT;
          default: dec_legal    = 1'b0;
        endcase
      end
      OP_ADDI: begin
        dec_legal    = 1'b1;
        dec_writes   = 1'b1;
        dec_alu_src  = 1'b1;
        dec_alu_ctrl = ALU_ADD;
        dec_dest     = rt;
        dec_imm      = imm_sext;
      end
      OP_ANDI: begin
        dec_legal    = 1'b1;
        dec_writes   = 1'b1;
        dec_alu_src  = 1'b1;
        dec_alu_ctrl = ALU_AND;
        dec_dest     = rt;
        dec_imm      = imm_zext;
      end
      OP_ORI: begin
        dec_legal    = 1'b1;
        dec_writes   = 1'b1;
        dec_alu_src  = 1'b1;
        dec_alu_ctrl = ALU_OR;
        dec_dest     = rt;
        dec_imm      = imm_zext;
      end
      OP_LW: begin
        dec_legal    = 1'b1;
        dec_writes   = 1'b1;
        dec_mem_read = 1'b1;
        dec_alu_src  = 1'b1;
        dec_alu_ctrl = ALU_ADD;
        dec_dest     = rt;
        dec_imm      = imm_sext;
      end
      OP_SW: begin
        dec_legal     = 1'b1;
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_alu_ctrl  = ALU_ADD;
        dec_imm       = imm_sext;
      end
      default: dec_legal = 1'b0;
    endcase
    // Unsupported encodings still occupy a slot but must not touch state downstream.
    if (!dec_legal) begin
      dec_writes    = 1'b0;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
      dec_alu_src   = 1'b0;
      dec_alu_ctrl  = ALU_AND;
      dec_dest      = 5'd0;
      dec_imm       = 32'd0;
    end
  end

  assign dec_reg_write = dec_writes && (dec_dest != 5'd0);

  // Writeback happens in the same cycle as the register-file read, so forward it here.
  logic [31:0] op_a;
  logic [31:0] op_b;

  assign op_a = (rs == 5'd0) ? 32'd0 : ((wb_write && wb_reg == rs) ? wb_data : reg0);
  assign op_b = (rt == 5'd0) ? 32'd0 : ((wb_write && wb_reg == rt) ? wb_data : reg1);

  logic adv;
  logic uses_rt;
  logic stall;
  logic take;

  assign adv     = !ex_valid || ex_ready;
  assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW);
  assign stall   = ex_valid && ex_mem_read && (ex_dest != 5'd0) &&
                   ((ex_dest == rs) || ((ex_dest == rt) && uses_rt));
  assign take    = if_valid && !stall;

  assign if_ready = !rst && (flush || (adv && !stall));

  // Reset, flush and bubbles all collapse to an empty slot with every field cleared.
  always_ff @(posedge cclk) begin
    if (rst || flush || (adv && !take)) begin
      ex_valid     <= 1'b0;
      ex_pc        <= 32'd0;
      ex_op_a      <= 32'd0;
      ex_op_b      <= 32'd0;
      ex_imm       <= 32'd0;
      ex_dest      <= 5'd0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_src   <= 1'b0;
      ex_alu_ctrl  <= 4'd0;
      ex_illegal   <= 1'b0;
    end else if (adv) begin
      ex_valid     <= 1'b1;
      ex_pc        <= if_pc;
      ex_op_a      <= op_a;
      ex_op_b      <= op_b;
      ex_imm       <= dec_imm;
      ex_dest      <= dec_dest;
      ex_reg_write <= dec_reg_write;
      ex_mem_read  <= dec_mem_read;
      ex_mem_write <= dec_mem_write;
      ex_alu_src   <= dec_alu_src;
      ex_alu_ctrl  <= dec_alu_ctrl;
      ex_illegal   <= !dec_legal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed vectors, corner sequences and randomized model check for decode_stage
module tb_decode_stage;

  logic        cclk = 1'b0;
  logic        rst, if_valid, if_ready, wb_write, flush, ex_ready;
  logic [31:0] if_instr, if_pc, reg0, reg1, wb_data;
  logic [4:0]  read_reg_0, read_reg_1, wb_reg;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_illegal;
  logic [31:0] ex_pc, ex_op_a, ex_op_b, ex_imm;
  logic [4:0]  ex_dest;
  logic [3:0]  ex_alu_ctrl;

  always #5 cclk = ~cclk;

  decode_stage dut (
    .cclk(cclk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .read_reg_0(read_reg_0), .read_reg_1(read_reg_1),
    .reg0(reg0), .reg1(reg1), .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_alu_ctrl(ex_alu_ctrl), .ex_illegal(ex_illegal)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, op_a, op_b, imm;
    logic [4:0]  dest;
    logic        rw, mr, mw, src;
    logic [3:0]  ctrl;
    logic        ill;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] instr, r0, r1;
    logic        wbw;
    logic [4:0]  wbr;
    logic [31:0] wbd;
    exp_t        e;
    logic        ci;
  } vec_t;

  typedef enum {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_ADDI, M_ANDI, M_ORI, M_LW, M_SW, M_ILL} mn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  task automatic check_ex(input string tag, input exp_t e, input logic payload, input logic imm_too);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(e.valid));
    chk({tag, ".dest"}, 32'(ex_dest), 32'(e.dest));
    chk({tag, ".reg_write"}, 32'(ex_reg_write), 32'(e.rw));
    chk({tag, ".mem_read"}, 32'(ex_mem_read), 32'(e.mr));
    chk({tag, ".mem_write"}, 32'(ex_mem_write), 32'(e.mw));
    chk({tag, ".alu_src"}, 32'(ex_alu_src), 32'(e.src));
    chk({tag, ".alu_ctrl"}, 32'(ex_alu_ctrl), 32'(e.ctrl));
    chk({tag, ".illegal"}, 32'(ex_illegal), 32'(e.ill));
    if (payload) begin
      chk({tag, ".pc"}, ex_pc, e.pc);
      chk({tag, ".op_a"}, ex_op_a, e.op_a);
      chk({tag, ".op_b"}, ex_op_b, e.op_b);
      if (imm_too) chk({tag, ".imm"}, ex_imm, e.imm);
    end
  endtask

  // flags = {reg_write, mem_read, mem_write, alu_src, illegal}
  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                              input logic [4:0] dest, input logic [3:0] ctrl, input logic [4:0] flags);
    exp_t e = '0;
    e.valid = 1'b1;
    e.op_a = a; e.op_b = b; e.imm = imm; e.dest = dest; e.ctrl = ctrl;
    {e.rw, e.mr, e.mw, e.src, e.ill} = flags;
    return e;
  endfunction

  function automatic mn_t classify(input logic [31:0] i);
    case (i[31:26])
      6'h00: case (i[5:0])
        6'h20: return M_ADD;
        6'h22: return M_SUB;
        6'h24: return M_AND;
        6'h25: return M_OR;
        6'h2A: return M_SLT;
        default: return M_ILL;
      endcase
      6'h08: return M_ADDI;
      6'h0C: return M_ANDI;
      6'h0D: return M_ORI;
      6'h23: return M_LW;
      6'h2B: return M_SW;
      default: return M_ILL;
    endcase
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf, input logic wbw,
                                          input logic [4:0] wbr, input logic [31:0] wbd);
    if (r == 5'd0) return 32'd0;
    if (wbw && wbr == r) return wbd;
    return rf;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] pc,
                                      input logic [31:0] r0, input logic [31:0] r1, input logic wbw,
                                      input logic [4:0] wbr, input logic [31:0] wbd);
    exp_t e = '0;
    mn_t mn = classify(instr);
    logic is_r = mn inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT};
    e.valid = 1'b1;
    e.pc = pc;
    e.op_a = operand(instr[25:21], r0, wbw, wbr, wbd);
    e.op_b = operand(instr[20:16], r1, wbw, wbr, wbd);
    if (mn == M_ILL) begin
      e.ill = 1'b1;
      return e;
    end
    case (mn)
      M_SUB: e.ctrl = 4'd6;
      M_AND, M_ANDI: e.ctrl = 4'd0;
      M_OR, M_ORI: e.ctrl = 4'd1;
      M_SLT: e.ctrl = 4'd7;
      default: e.ctrl = 4'd2;
    endcase
    e.src = !is_r;
    e.dest = is_r ? instr[15:11] : ((mn == M_SW) ? 5'd0 : instr[20:16]);
    e.rw = (mn != M_SW) && (e.dest != 5'd0);
    e.mr = (mn == M_LW);
    e.mw = (mn == M_SW);
    if (is_r) e.imm = 32'd0;
    else if (mn == M_ANDI || mn == M_ORI) e.imm = {16'd0, instr[15:0]};
    else e.imm = {{16{instr[15]}}, instr[15:0]};
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [5:0] ops [5] = '{6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B};
    int k = int'($urandom_range(0, 11));
    logic [4:0] rs = 5'($urandom_range(0, 3));
    logic [4:0] rt = 5'($urandom_range(0, 3));
    logic [4:0] rd = 5'($urandom_range(0, 3));
    if (k < 5) return {6'h00, rs, rt, rd, 5'd0, fns[k]};
    if (k < 10) return {ops[k-5], rs, rt, 16'($urandom)};
    return $urandom;
  endfunction

  vec_t vecs[$];
  exp_t e, m, nm;
  logic adv_m, stall_m, er;
  logic [4:0] rs_m, rt_m;
  logic [5:0] opc_m;

  initial begin
    rst = 1'b1; if_valid = 1'b1; if_instr = 32'h00221820; if_pc = 32'h100;
    reg0 = 32'd5; reg1 = 32'd7; wb_write = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
    flush = 1'b0; ex_ready = 1'b1;

    #1 chk("rst.if_ready", 32'(if_ready), 32'd0);
    tick();
    check_ex("rst", '0, 1'b1, 1'b1);
    rst = 1'b0; if_valid = 1'b0;
    tick();

    vecs.push_back('{"add", 32'h00221820, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0, mk(32'd5, 32'd7, 32'd0, 5'd3, 4'd2, 5'b10000), 1'b1});
    vecs.push_back('{"addi_neg", 32'h2004FFFF, 32'h99, 32'h12, 1'b0, 5'd0, 32'd0, mk(32'd0, 32'h12, 32'hFFFFFFFF, 5'd4, 4'd2, 5'b10010), 1'b1});
    vecs.push_back('{"ori_zext", 32'h3404FFFF, 32'h99, 32'h12, 1'b0, 5'd0, 32'd0, mk(32'd0, 32'h12, 32'h0000FFFF, 5'd4, 4'd1, 5'b10010), 1'b1});
    vecs.push_back('{"andi", 32'h30278001, 32'h31, 32'h44, 1'b0, 5'd0, 32'd0, mk(32'h31, 32'h44, 32'h8001, 5'd7, 4'd0, 5'b10010), 1'b1});
    vecs.push_back('{"sub", 32'h00221822, 32'd9, 32'd4, 1'b0, 5'd0, 32'd0, mk(32'd9, 32'd4, 32'd0, 5'd3, 4'd6, 5'b10000), 1'b1});
    vecs.push_back('{"and", 32'h00221824, 32'd9, 32'd4, 1'b0, 5'd0, 32'd0, mk(32'd9, 32'd4, 32'd0, 5'd3, 4'd0, 5'b10000), 1'b1});
    vecs.push_back('{"or", 32'h00221825, 32'd9, 32'd4, 1'b0, 5'd0, 32'd0, mk(32'd9, 32'd4, 32'd0, 5'd3, 4'd1, 5'b10000), 1'b1});
    vecs.push_back('{"slt", 32'h0022182A, 32'd9, 32'd4, 1'b0, 5'd0, 32'd0, mk(32'd9, 32'd4, 32'd0, 5'd3, 4'd7, 5'b10000), 1'b1});
    vecs.push_back('{"lw", 32'h8C25FFFC, 32'h100, 32'd3, 1'b0, 5'd0, 32'd0, mk(32'h100, 32'd3, 32'hFFFFFFFC, 5'd5, 4'd2, 5'b11010), 1'b1});
    vecs.push_back('{"sw", 32'hAC220008, 32'h200, 32'hBEEF, 1'b0, 5'd0, 32'd0, mk(32'h200, 32'hBEEF, 32'd8, 5'd0, 4'd2, 5'b00110), 1'b1});
    vecs.push_back('{"add_r0dest", 32'h00220020, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0, mk(32'd1, 32'd2, 32'd0, 5'd0, 4'd2, 5'b00000), 1'b1});
    vecs.push_back('{"byp_a", 32'h00221820, 32'h11, 32'd7, 1'b1, 5'd1, 32'h55, mk(32'h55, 32'd7, 32'd0, 5'd3, 4'd2, 5'b10000), 1'b1});
    vecs.push_back('{"byp_wbreg0", 32'h00221820, 32'h11, 32'd7, 1'b1, 5'd0, 32'h55, mk(32'h11, 32'd7, 32'd0, 5'd3, 4'd2, 5'b10000), 1'b1});
    vecs.push_back('{"byp_nowrite", 32'h00221820, 32'h11, 32'd7, 1'b0, 5'd1, 32'h55, mk(32'h11, 32'd7, 32'd0, 5'd3, 4'd2, 5'b10000), 1'b1});
    vecs.push_back('{"byp_b", 32'h00221820, 32'h11, 32'd7, 1'b1, 5'd2, 32'hAA, mk(32'h11, 32'hAA, 32'd0, 5'd3, 4'd2, 5'b10000), 1'b1});
    vecs.push_back('{"r0_zero", 32'h2004FFFF, 32'h99, 32'h12, 1'b1, 5'd0, 32'h77, mk(32'd0, 32'h12, 32'hFFFFFFFF, 5'd4, 4'd2, 5'b10010), 1'b1});
    vecs.push_back('{"bad_op", 32'hFC221820, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0, mk(32'd5, 32'd7, 32'd0, 5'd0, 4'd0, 5'b00001), 1'b0});
    vecs.push_back('{"bad_fn", 32'h00221821, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0, mk(32'd5, 32'd7, 32'd0, 5'd0, 4'd0, 5'b00001), 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      if_instr = vecs[i].instr; if_pc = 32'h400 + 32'(i * 4);
      reg0 = vecs[i].r0; reg1 = vecs[i].r1;
      wb_write = vecs[i].wbw; wb_reg = vecs[i].wbr; wb_data = vecs[i].wbd;
      if_valid = 1'b1; ex_ready = 1'b1; flush = 1'b0;
      #1 chk({vecs[i].name, ".if_ready"}, 32'(if_ready), 32'd1);
      chk({vecs[i].name, ".read_reg_0"}, 32'(read_reg_0), 32'(vecs[i].instr >> 21) & 32'h1F);
      e = vecs[i].e;
      e.pc = if_pc;
      tick();
      check_ex(vecs[i].name, e, 1'b1, vecs[i].ci);
      if_valid = 1'b0; wb_write = 1'b0;
      tick();
      chk({vecs[i].name, ".drain"}, 32'(ex_valid), 32'd0);
    end

    // load-use: one bubble, then the dependent ADD goes through
    if_valid = 1'b1; if_instr = 32'h8C250000; reg0 = 32'h40; ex_ready = 1'b1;
    tick();
    chk("lu.lw_mem_read", 32'(ex_mem_read), 32'd1);
    if_instr = 32'h00A23020;
    #1 chk("lu.stall_ready", 32'(if_ready), 32'd0);
    tick();
    chk("lu.bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu.bubble_rw", 32'(ex_reg_write), 32'd0);
    chk("lu.bubble_mr", 32'(ex_mem_read), 32'd0);
    chk("lu.retry_ready", 32'(if_ready), 32'd1);
    tick();
    chk("lu.add_valid", 32'(ex_valid), 32'd1);
    chk("lu.add_dest", 32'(ex_dest), 32'd6);
    if_instr = 32'h8C250000;
    tick();
    if_instr = 32'h00E23020;
    #1 chk("lu.indep_ready", 32'(if_ready), 32'd1);
    tick();
    chk("lu.indep_valid", 32'(ex_valid), 32'd1);
    chk("lu.indep_dest", 32'(ex_dest), 32'd6);

    // backpressure holds the slot, then flush empties it
    if_instr = 32'h00221820; if_pc = 32'h800; reg0 = 32'd5; reg1 = 32'd7;
    tick();
    e = mk(32'd5, 32'd7, 32'd0, 5'd3, 4'd2, 5'b10000);
    e.pc = 32'h800;
    ex_ready = 1'b0; if_instr = 32'h2004FFFF; if_pc = 32'h804;
    for (int i = 0; i < 3; i++) begin
      if_valid = (i != 1); reg0 = $urandom; reg1 = $urandom;
      #1 chk("bp.if_ready", 32'(if_ready), 32'd0);
      tick();
      check_ex("bp.hold", e, 1'b1, 1'b1);
    end
    flush = 1'b1;
    #1 chk("bp.flush_ready", 32'(if_ready), 32'd1);
    tick();
    chk("bp.flush_valid", 32'(ex_valid), 32'd0);
    chk("bp.flush_rw", 32'(ex_reg_write), 32'd0);
    flush = 1'b0;

    // reset while stalled and back-pressured: everything clears, no replay
    ex_ready = 1'b1; if_valid = 1'b1; if_instr = 32'h8C250000;
    tick();
    if_instr = 32'h00A23020; ex_ready = 1'b0;
    #1 chk("rs.stall_ready", 32'(if_ready), 32'd0);
    rst = 1'b1;
    #1 chk("rs.rst_ready", 32'(if_ready), 32'd0);
    tick();
    check_ex("rs.clear", '0, 1'b1, 1'b1);
    rst = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    tick();
    chk("rs.no_replay", 32'(ex_valid), 32'd0);

    // randomized run against the reference model
    m = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 19) == 0);
      if_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 9) < 7);
      if_instr = rand_instr(); if_pc = $urandom;
      reg0 = $urandom; reg1 = $urandom;
      wb_write = ($urandom_range(0, 1) == 1); wb_reg = 5'($urandom_range(0, 3)); wb_data = $urandom;
      #1;
      opc_m = if_instr[31:26]; rs_m = if_instr[25:21]; rt_m = if_instr[20:16];
      adv_m = !m.valid || ex_ready;
      stall_m = m.valid && m.mr && m.dest != 5'd0 &&
                (m.dest == rs_m || (m.dest == rt_m && (opc_m == 6'h00 || opc_m == 6'h2B)));
      er = !rst && (flush || (adv_m && !stall_m));
      chk("rnd.if_ready", 32'(if_ready), 32'(er));
      chk("rnd.read_reg_0", 32'(read_reg_0), 32'(rs_m));
      chk("rnd.read_reg_1", 32'(read_reg_1), 32'(rt_m));
      if (rst || flush) nm = '0;
      else if (adv_m) nm = (if_valid && !stall_m) ?
        ref_decode(if_instr, if_pc, reg0, reg1, wb_write, wb_reg, wb_data) : '0;
      else nm = m;
      tick();
      m = nm;
      check_ex("rnd", m, m.valid, !m.ill);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
